vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for 640x480@60 VGA. Produces the pixel X/Y counts,
//  sync pulses and frame tick consumed by the bird controller, pipe logic and
//  colour mux. Runs on the system clock and derives the pixel rate through a
//  clock-enable divider. Sits directly upstream of the bird control FSM.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel (100 MHz -> 25 MHz), >=1
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels (XMAX = sum = 800)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines (YMAX = sum = 525)
// PORTS
//  i_Clk          in   1                  system clock
//  i_Reset_n      in   1                  asynchronous, active-low reset
//  o_X_Count      out  $clog2(XMAX)       pixel column 0..XMAX-1
//  o_Y_Count      out  $clog2(YMAX)       line 0..YMAX-1
//  o_HSync        out  1                  horizontal sync, active low
//  o_VSync        out  1                  vertical sync, active low
//  o_Active       out  1                  1 when X<H_ACTIVE and Y<V_ACTIVE
//  o_Pix_En       out  1                  1-clock strobe, counters advance on this edge
//  o_Frame_Start  out  1                  1-clock pulse when counters wrap to (0,0)
// BEHAVIOUR
//  - Reset (async assert, sync release): div cnt=0, X=0, Y=0, HSync=1, VSync=1,
//    Active=0, Frame_Start=0; o_Pix_En=0 while reset is asserted.
//  - Divider: div cnt counts 0..CLK_DIV-1, wraps to 0. Width max(1,$clog2(CLK_DIV)).
//    o_Pix_En = (div cnt == CLK_DIV-1), combinational. CLK_DIV=1 -> Pix_En constantly 1.
//  - On a clock edge with Pix_En=1: X<=X+1; if X==XMAX-1, X<=0 and Y<=Y+1;
//    if also Y==YMAX-1, Y<=0. Counters hold otherwise.
//  - HSync, VSync and Active are registered, decoded from the next X/Y values, so
//    they are aligned with o_X_Count/o_Y_Count (zero relative latency).
//    HSync=0 iff H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC (656..751).
//    VSync=0 iff V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC (490..491).
//  - First frame only: (0,0) reports Active=0 (reset value); every later frame
//    decodes normally.
//  - Frame_Start: registered, high for exactly one i_Clk cycle after the edge on
//    which counters wrap (XMAX-1,YMAX-1)->(0,0); low otherwise. Not raised by reset.
//  - Reset asserted mid-line/frame: all state returns to reset values immediately.
//    After release, the first advance occurs on the CLK_DIV-th rising edge.
//  - Counts never exceed XMAX-1/YMAX-1. Any out-of-range value reached by upset
//    wraps to 0 on the next Pix_En.
// STRUCTURE
//  - Package vga_timing_pkg: H_*/V_* defaults, XMAX/YMAX, sync-start/end
//    localparams, count widths. bird_ctrl_fsm and other consumers share it.
//  - Sub-module pix_clk_en (divider producing o_Pix_En). Counters and decode stay
//    in this module.
// TESTING
//  1 Reset release, CLK_DIV=4 -> Pix_En high on clocks 4,8,12..; X=1 after
//    4th edge; HSync=VSync=1.
//  2 Run one line -> X 799->0 with Y 0->1 on the same edge; HSync low for exactly
//    384 clocks starting at X=656.
//  3 Run full frame -> VSync low for 2 lines (Y=490,491, 6400 clocks); Frame_Start
//    pulses once every 1,680,000 clocks, width 1 clock.
//  4 Check Active over a frame -> high at (639,479), low at (640,0) and (0,480);
//    307,200 active pixels per frame from frame 2 on.
//  5 Assert i_Reset_n low at X=300,Y=200 between clock edges -> outputs hit reset
//    values without waiting for a clock; counting restarts cleanly after release.
//  6 CLK_DIV=1 build -> Pix_En constantly 1; line period 800 clocks, frame
//    period 420,000 clocks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants for the sync generator and its consumers.
package vga_timing_pkg;

  localparam int VGA_CLK_DIV  = 4;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_XMAX     = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_YMAX     = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows: start inclusive, end exclusive.
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  localparam int VGA_X_W      = $clog2(VGA_XMAX);
  localparam int VGA_Y_W      = $clog2(VGA_YMAX);

  // Counter width for a modulo-n counter, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable divider: one-cycle strobe every CLK_DIV system clocks.
module pix_clk_en
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  output logic o_Pix_En
);

  localparam int unsigned DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Modulo-CLK_DIV count of system clocks.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Strobe is gated by reset so it stays low while reset is held.
  assign o_Pix_En = i_Reset_n & (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: X/Y counters, registered sync/active decode, frame tick.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter  int CLK_DIV  = VGA_CLK_DIV,
  parameter  int H_ACTIVE = VGA_H_ACTIVE,
  parameter  int H_FP     = VGA_H_FP,
  parameter  int H_SYNC   = VGA_H_SYNC,
  parameter  int H_BP     = VGA_H_BP,
  parameter  int V_ACTIVE = VGA_V_ACTIVE,
  parameter  int V_FP     = VGA_V_FP,
  parameter  int V_SYNC   = VGA_V_SYNC,
  parameter  int V_BP     = VGA_V_BP,
  localparam int XMAX     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int YMAX     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(XMAX),
  localparam int YW       = $clog2(YMAX)
) (
  input  logic          i_Clk,
  input  logic          i_Reset_n,
  output logic [XW-1:0] o_X_Count,
  output logic [YW-1:0] o_Y_Count,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_Active,
  output logic          o_Pix_En,
  output logic          o_Frame_Start
);

  localparam logic [XW-1:0] X_LAST   = XW'(XMAX - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(YMAX - 1);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);

  logic          pix_en;
  logic [XW-1:0] x_q, x_next;
  logic [YW-1:0] y_q, y_next;
  logic          hsync_q, vsync_q, active_q, frame_start_q;
  logic          frame_wrap;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .o_Pix_En  (pix_en)
  );

  // Next raster position; >= on the wrap tests returns upset values to 0.
  always_comb begin
    x_next     = x_q + 1'b1;
    y_next     = y_q;
    frame_wrap = 1'b0;
    if (x_q >= X_LAST) begin
      x_next = '0;
      if (y_q >= Y_LAST) begin
        y_next     = '0;
        frame_wrap = pix_en;
      end else begin
        y_next = y_q + 1'b1;
      end
    end
  end

  // Counters and decode advance only on pixel strobes; decoding the next
  // position keeps sync/active aligned with the counts. Holding decode between
  // strobes is what leaves (0,0) of the first frame at the reset Active=0.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_wrap;
      if (pix_en) begin
        x_q      <= x_next;
        y_q      <= y_next;
        hsync_q  <= !((x_next >= HS_START) && (x_next < HS_END));
        vsync_q  <= !((y_next >= VS_START) && (y_next < VS_END));
        active_q <= (x_next < X_ACT) && (y_next < Y_ACT);
      end
    end
  end

  assign o_X_Count     = x_q;
  assign o_Y_Count     = y_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Pix_En      = pix_en;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing for line-level checks, plus two
// shrunken rasters (15x8, CLK_DIV=2 and CLK_DIV=1) for frame-level checks.
module tb_vga_sync_gen;

  logic clk;
  logic rst_n;

  logic [9:0] d_X, d_Y;
  logic       d_HS, d_VS, d_Act, d_Pe, d_Fs;
  logic [3:0] s_X;
  logic [2:0] s_Y;
  logic       s_HS, s_VS, s_Act, s_Pe, s_Fs;
  logic [3:0] v_X;
  logic [2:0] v_Y;
  logic       v_HS, v_VS, v_Act, v_Pe, v_Fs;

  int n_cmp = 0;
  int n_bad = 0;

  vga_sync_gen u_def (
    .i_Clk(clk), .i_Reset_n(rst_n), .o_X_Count(d_X), .o_Y_Count(d_Y),
    .o_HSync(d_HS), .o_VSync(d_VS), .o_Active(d_Act), .o_Pix_En(d_Pe),
    .o_Frame_Start(d_Fs)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .i_Clk(clk), .i_Reset_n(rst_n), .o_X_Count(s_X), .o_Y_Count(s_Y),
    .o_HSync(s_HS), .o_VSync(s_VS), .o_Active(s_Act), .o_Pix_En(s_Pe),
    .o_Frame_Start(s_Fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_div1 (
    .i_Clk(clk), .i_Reset_n(rst_n), .o_X_Count(v_X), .o_Y_Count(v_Y),
    .o_HSync(v_HS), .o_VSync(v_VS), .o_Active(v_Act), .o_Pix_En(v_Pe),
    .o_Frame_Start(v_Fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_low, vs_low;
    int s_fs_cnt, s_fs_first, s_fs_last, s_fs_adj, s_vs_low, s_act1, s_act2;
    int v_fs_cnt, v_fs_first, v_pe_low, v_x0;
    logic s_fs_prev;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    chk("rst_X", d_X, 0);
    chk("rst_Y", d_Y, 0);
    chk("rst_HS", d_HS, 1);
    chk("rst_VS", d_VS, 1);
    chk("rst_Act", d_Act, 0);
    chk("rst_Fs", d_Fs, 0);
    chk("rst_Pe", d_Pe, 0);
    chk("rst_Pe_div1", v_Pe, 0);
    chk("rst_Pe_small", s_Pe, 0);

    // Release: strobe during clock 4, first advance on the 4th edge
    rst_n = 1'b1;
    tick(1); chk("rel_pe_e1", d_Pe, 0);
    tick(1); chk("rel_pe_e2", d_Pe, 0);
    tick(1); chk("rel_pe_e3", d_Pe, 1); chk("rel_X_e3", d_X, 0);
    tick(1);
    chk("rel_X_e4", d_X, 1);
    chk("rel_pe_e4", d_Pe, 0);
    chk("rel_HS_e4", d_HS, 1);
    chk("rel_VS_e4", d_VS, 1);
    chk("rel_Act_e4", d_Act, 1);
    tick(3); chk("rel_pe_e7", d_Pe, 1);
    tick(1); chk("rel_X_e8", d_X, 2);

    // One line: X=655 entered at edge 2620, X=799 at edge 3196
    tick(2612);
    chk("line_X655", d_X, 655);
    chk("line_HS655", d_HS, 1);
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i < 576; i++) begin
      tick(1);
      if (d_HS == 1'b0) hs_low++;
      if (d_VS == 1'b0) vs_low++;
    end
    chk("line_hs_low_clks", hs_low, 384);
    chk("line_vs_low_clks", vs_low, 0);
    chk("line_X799", d_X, 799);
    chk("line_Y799", d_Y, 0);
    chk("line_HS799", d_HS, 1);
    chk("line_Act799", d_Act, 0);
    tick(3);
    chk("line_pe_wrap", d_Pe, 1);
    chk("line_X_prewrap", d_X, 799);
    tick(1);
    chk("line_X_wrap", d_X, 0);
    chk("line_Y_wrap", d_Y, 1);
    chk("line_Act_x0y1", d_Act, 1);
    chk("line_Fs_nowrap", d_Fs, 0);

    // Async reset mid-line at X=300, Y=1
    tick(1200);
    chk("mid_X300", d_X, 300);
    chk("mid_Y1", d_Y, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_X", d_X, 0);
    chk("async_Y", d_Y, 0);
    chk("async_HS", d_HS, 1);
    chk("async_VS", d_VS, 1);
    chk("async_Act", d_Act, 0);
    chk("async_Pe", d_Pe, 0);
    chk("async_s_X", s_X, 0);
    chk("async_v_X", v_X, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3); chk("restart_X_e3", d_X, 0); chk("restart_pe_e3", d_Pe, 1);
    tick(1); chk("restart_X_e4", d_X, 1); chk("restart_Y_e4", d_Y, 0);

    // Frame-level checks on the shrunken rasters
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    s_fs_cnt = 0; s_fs_first = -1; s_fs_last = -1; s_fs_adj = 0;
    s_vs_low = 0; s_act1 = 0; s_act2 = 0;
    v_fs_cnt = 0; v_fs_first = -1; v_pe_low = 0; v_x0 = 0;
    s_fs_prev = 1'b0;
    for (int k = 1; k <= 760; k++) begin
      tick(1);
      if (s_Fs) begin
        s_fs_cnt++;
        if (s_fs_first < 0) s_fs_first = k;
        s_fs_last = k;
        if (s_fs_prev) s_fs_adj++;
      end
      s_fs_prev = s_Fs;
      if (k < 240 && s_Act) s_act1++;
      if (k >= 240 && k < 480 && s_Act) s_act2++;
      if (k >= 240 && k < 480 && !s_VS) s_vs_low++;
      if (v_Fs) begin
        v_fs_cnt++;
        if (v_fs_first < 0) v_fs_first = k;
      end
      if (!v_Pe) v_pe_low++;
      if (k <= 750 && v_X == 4'd0) v_x0++;
      if (k == 240) begin
        chk("s_wrap_X", s_X, 0); chk("s_wrap_Y", s_Y, 0);
        chk("s_wrap_Act", s_Act, 1); chk("s_wrap_Fs", s_Fs, 1);
      end
      if (k == 256) begin chk("s_x8y0_X", s_X, 8); chk("s_x8y0_Act", s_Act, 0); end
      if (k == 258) chk("s_x9_HS", s_HS, 1);
      if (k == 260) begin chk("s_x10_X", s_X, 10); chk("s_x10_HS", s_HS, 0); end
      if (k == 266) begin chk("s_x13_X", s_X, 13); chk("s_x13_HS", s_HS, 1); end
      if (k == 344) begin
        chk("s_x7y3_X", s_X, 7); chk("s_x7y3_Y", s_Y, 3); chk("s_x7y3_Act", s_Act, 1);
      end
      if (k == 360) begin
        chk("s_x0y4_X", s_X, 0); chk("s_x0y4_Y", s_Y, 4); chk("s_x0y4_Act", s_Act, 0);
      end
    end
    chk("s_fs_count", s_fs_cnt, 3);
    chk("s_fs_first", s_fs_first, 240);
    chk("s_fs_last", s_fs_last, 720);
    chk("s_fs_width", s_fs_adj, 0);
    chk("s_vs_low_clks", s_vs_low, 60);
    chk("s_act_frame1", s_act1, 62);
    chk("s_act_frame2", s_act2, 64);
    chk("v_fs_count", v_fs_cnt, 6);
    chk("v_fs_first", v_fs_first, 120);
    chk("v_pe_low", v_pe_low, 0);
    chk("v_line_wraps", v_x0, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
